// File: rtl/data_island_scheduler_pkg.sv
// Shared types and constants for the HDMI data-island scheduler.
//   period_e : video period reported to the TMDS/TERC4 encoders
//   phase_e  : internal island sequencing phases
//   NULL_ID  : packet_sel value for a slot that carries a NULL packet
//   SRC_*    : requester indices (lower index = higher fixed priority)
package data_island_scheduler_pkg;

  typedef enum logic [1:0] {
    PERIOD_CONTROL  = 2'd0,
    PERIOD_PREAMBLE = 2'd1,
    PERIOD_GUARD    = 2'd2,
    PERIOD_DATA     = 2'd3
  } period_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_LEAD_GB  = 3'd2,
    ST_DATA     = 3'd3,
    ST_TRAIL_GB = 3'd4
  } phase_e;

  localparam int              IDX_W        = 3;
  localparam logic [IDX_W-1:0] NULL_ID     = 3'd7;
  localparam int              PREAMBLE_LEN = 8;
  localparam int              GB_LEN       = 2;
  localparam int              PACKET_LEN   = 32;

  localparam int SRC_AUDIO    = 0;
  localparam int SRC_ACR      = 1;
  localparam int SRC_AVI      = 2;
  localparam int SRC_SPD      = 3;
  localparam int SRC_AUDIO_IF = 4;

endpackage

// File: rtl/data_island_scheduler_if.sv
// Bundle between packet sources / timing generator and the island scheduler.
//   cx, req                          : driven by the master (timing + sources)
//   grant, mode, packet_sel,
//   packet_start, data_counter,
//   num_packets                      : driven by the scheduler (slave)
interface data_island_scheduler_if #(
  parameter int BIT_WIDTH = 10,
  parameter int NUM_SRC   = 5
) ();
  import data_island_scheduler_pkg::*;

  logic [BIT_WIDTH-1:0] cx;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   grant;
  period_e              mode;
  logic [IDX_W-1:0]     packet_sel;
  logic                 packet_start;
  logic [4:0]           data_counter;
  logic [4:0]           num_packets;

  modport master (
    output cx, req,
    input  grant, mode, packet_sel, packet_start, data_counter, num_packets
  );

  modport slave (
    input  cx, req,
    output grant, mode, packet_sel, packet_start, data_counter, num_packets
  );
endinterface

// File: rtl/data_island_scheduler_packet_arbiter.sv
// Combinational slot arbiter.
//   i_req     : requests eligible for this slot
//   i_ptr     : round-robin pointer (always in [RR_BASE, NUM_SRC-1])
//   o_idx     : winning source index (NULL_ID when none)
//   o_valid   : a winner exists
//   o_ptr_nxt : pointer after this slot (moves only on a round-robin win)
// Sources below RR_BASE win by fixed priority (index 0 highest) before the
// round-robin group is considered at all.
module packet_arbiter
  import data_island_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 5,
  parameter int RR_BASE = 2
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_ptr_nxt
);
  localparam int NUM_RR = NUM_SRC - RR_BASE;

  logic [IDX_W-1:0] w_cand;
  int               w_sum;

  always_comb begin
    o_valid   = 1'b0;
    o_idx     = NULL_ID;
    o_ptr_nxt = i_ptr;
    w_cand    = '0;
    w_sum     = 0;

    for (int i = 0; i < RR_BASE; i++) begin
      if (!o_valid && i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end

    // Scan the RR group starting at the pointer, folding back to RR_BASE.
    for (int k = 0; k < NUM_RR; k++) begin
      w_sum  = int'(i_ptr) + k;
      if (w_sum >= NUM_SRC) w_sum = w_sum - NUM_RR;
      w_cand = IDX_W'(w_sum);
      if (!o_valid && i_req[w_cand]) begin
        o_valid   = 1'b1;
        o_idx     = w_cand;
        o_ptr_nxt = (w_sum + 1 >= NUM_SRC) ? IDX_W'(RR_BASE) : IDX_W'(w_sum + 1);
      end
    end
  end
endmodule

// File: rtl/data_island_scheduler.sv
// Per-line HDMI data-island sequencer and packet-slot arbiter.
//   clk_pixel : pixel clock
//   reset_n   : asynchronous active-low reset
//   bus       : slave side of data_island_scheduler_if
//               (cx, req in; grant, mode, packet_sel, packet_start,
//                data_counter, num_packets out)
// Every output is registered and describes the cycle whose cx is one more
// than the cx sampled at the preceding edge.  The island length is fixed at
// the decide cycle (cx == ISLAND_START-1); after that the phase sequence runs
// on its own counters and ignores cx.
module data_island_scheduler
  import data_island_scheduler_pkg::*;
#(
  parameter int BIT_WIDTH    = 10,
  parameter int NUM_SRC      = 5,
  parameter int RR_BASE      = 2,
  parameter int ISLAND_START = 644,
  parameter int ISLAND_END   = 800,
  parameter int MAX_PACKETS  = 18
) (
  input logic                    clk_pixel,
  input logic                    reset_n,
  data_island_scheduler_if.slave bus
);
  localparam int FIT_RAW = (ISLAND_END - ISLAND_START - PREAMBLE_LEN - 2*GB_LEN) / PACKET_LEN;
  localparam int FIT     = (FIT_RAW < MAX_PACKETS) ? FIT_RAW : MAX_PACKETS;
  localparam logic [BIT_WIDTH-1:0] DECIDE_CX = BIT_WIDTH'(ISLAND_START - 1);

  phase_e             r_state,        w_state_nxt;
  logic [2:0]         r_phase_cnt,    w_phase_cnt_nxt;
  logic [4:0]         r_slot,         w_slot_nxt;
  logic [4:0]         r_data_counter, w_data_counter_nxt;
  logic [4:0]         r_num_packets,  w_num_packets_nxt;
  logic [IDX_W-1:0]   r_rr_ptr,       w_rr_ptr_nxt;
  logic [NUM_SRC-1:0] r_grant,        w_grant_nxt;
  period_e            r_mode,         w_mode_nxt;
  logic [IDX_W-1:0]   r_packet_sel,   w_packet_sel_nxt;
  logic               r_packet_start, w_packet_start_nxt;

  logic               w_slot_start;
  logic [5:0]         w_req_count;
  logic [4:0]         w_decide_n;
  logic [NUM_SRC-1:0] w_arb_req;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [IDX_W-1:0]   w_arb_ptr_nxt;
  logic               w_arb_valid;

  function automatic period_e phase_mode(input phase_e s);
    case (s)
      ST_PREAMBLE:            return PERIOD_PREAMBLE;
      ST_LEAD_GB, ST_TRAIL_GB: return PERIOD_GUARD;
      ST_DATA:                return PERIOD_DATA;
      default:                return PERIOD_CONTROL;
    endcase
  endfunction

  // A source whose grant is on the outputs right now is still shown as
  // requesting (it drops on the next cycle); never let it win twice.
  assign w_arb_req = bus.req & ~r_grant;

  packet_arbiter #(
    .NUM_SRC (NUM_SRC),
    .RR_BASE (RR_BASE)
  ) u_arb (
    .i_req     (w_arb_req),
    .i_ptr     (r_rr_ptr),
    .o_idx     (w_arb_idx),
    .o_valid   (w_arb_valid),
    .o_ptr_nxt (w_arb_ptr_nxt)
  );

  always_comb begin
    w_req_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_req_count = w_req_count + 6'(bus.req[i]);
    end
    w_decide_n = (w_req_count > 6'(FIT)) ? 5'(FIT) : w_req_count[4:0];
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_phase_cnt_nxt    = r_phase_cnt;
    w_slot_nxt         = r_slot;
    w_data_counter_nxt = 5'd0;
    w_num_packets_nxt  = r_num_packets;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_grant_nxt        = '0;
    w_packet_sel_nxt   = r_packet_sel;
    w_packet_start_nxt = 1'b0;
    w_slot_start       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_packet_sel_nxt = NULL_ID;
        if (bus.cx == DECIDE_CX) begin
          w_num_packets_nxt = w_decide_n;
          if (w_decide_n != 5'd0) begin
            w_state_nxt     = ST_PREAMBLE;
            w_phase_cnt_nxt = 3'd0;
          end
        end
      end
      ST_PREAMBLE: begin
        if (r_phase_cnt == 3'(PREAMBLE_LEN - 1)) begin
          w_state_nxt     = ST_LEAD_GB;
          w_phase_cnt_nxt = 3'd0;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + 3'd1;
        end
      end
      ST_LEAD_GB: begin
        if (r_phase_cnt == 3'(GB_LEN - 1)) begin
          w_state_nxt  = ST_DATA;
          w_slot_nxt   = 5'd0;
          w_slot_start = 1'b1;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + 3'd1;
        end
      end
      ST_DATA: begin
        if (r_data_counter == 5'(PACKET_LEN - 1)) begin
          if (r_slot == r_num_packets - 5'd1) begin
            w_state_nxt      = ST_TRAIL_GB;
            w_phase_cnt_nxt  = 3'd0;
            w_packet_sel_nxt = NULL_ID;
          end else begin
            w_slot_nxt   = r_slot + 5'd1;
            w_slot_start = 1'b1;
          end
        end else begin
          w_data_counter_nxt = r_data_counter + 5'd1;
        end
      end
      ST_TRAIL_GB: begin
        if (r_phase_cnt == 3'(GB_LEN - 1)) begin
          w_state_nxt     = ST_IDLE;
          w_phase_cnt_nxt = 3'd0;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // First cycle of a slot: packet_start always, grant only with a winner.
    if (w_slot_start) begin
      w_packet_start_nxt = 1'b1;
      if (w_arb_valid) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          w_grant_nxt[i] = (w_arb_idx == IDX_W'(i));
        end
        w_packet_sel_nxt = w_arb_idx;
        w_rr_ptr_nxt     = w_arb_ptr_nxt;
      end else begin
        w_packet_sel_nxt = NULL_ID;
      end
    end

    w_mode_nxt = phase_mode(w_state_nxt);
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_phase_cnt    <= 3'd0;
      r_slot         <= 5'd0;
      r_data_counter <= 5'd0;
      r_num_packets  <= 5'd0;
      r_rr_ptr       <= IDX_W'(RR_BASE);
      r_grant        <= '0;
      r_mode         <= PERIOD_CONTROL;
      r_packet_sel   <= NULL_ID;
      r_packet_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase_cnt    <= w_phase_cnt_nxt;
      r_slot         <= w_slot_nxt;
      r_data_counter <= w_data_counter_nxt;
      r_num_packets  <= w_num_packets_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_grant        <= w_grant_nxt;
      r_mode         <= w_mode_nxt;
      r_packet_sel   <= w_packet_sel_nxt;
      r_packet_start <= w_packet_start_nxt;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.mode         = r_mode;
  assign bus.packet_sel   = r_packet_sel;
  assign bus.packet_start = r_packet_start;
  assign bus.data_counter = r_data_counter;
  assign bus.num_packets  = r_num_packets;

endmodule

// File: tb/tb_data_island_scheduler.sv
`timescale 1ns/1ps
module tb_data_island_scheduler;
  import data_island_scheduler_pkg::*;

  localparam int BIT_WIDTH    = 10;
  localparam int NUM_SRC      = 5;
  localparam int RR_BASE      = 2;
  localparam int ISLAND_START = 644;
  localparam int ISLAND_END   = 800;
  localparam int MAX_PACKETS  = 18;
  localparam int H_TOTAL      = 858;
  localparam int FIT          = 4;   // min(18, (800-644-12)/32)

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  data_island_scheduler_if #(.BIT_WIDTH(BIT_WIDTH), .NUM_SRC(NUM_SRC)) bus ();

  data_island_scheduler #(
    .BIT_WIDTH    (BIT_WIDTH),
    .NUM_SRC      (NUM_SRC),
    .RR_BASE      (RR_BASE),
    .ISLAND_START (ISLAND_START),
    .ISLAND_END   (ISLAND_END),
    .MAX_PACKETS  (MAX_PACKETS)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Island model: offset from first preamble cycle decides the period.
  bit        m_on;
  int        m_off;
  int        m_n;
  int        m_ptr;
  int        s_cx;
  int        grant_total;
  period_e   exp_mode;
  logic [4:0] exp_grant;
  logic [2:0] exp_sel;
  logic       exp_pstart;
  logic [4:0] exp_dc;
  logic [4:0] exp_num;

  period_e    mode_at  [H_TOTAL];
  logic [2:0] sel_at   [H_TOTAL];
  logic [4:0] grant_at [H_TOTAL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (sampled cx %0d): got %0d required %0d", name, s_cx, act, expv);
    end
  endtask

  task automatic model_reset();
    m_on       = 1'b0;
    m_off      = 0;
    m_n        = 0;
    m_ptr      = RR_BASE;
    exp_mode   = PERIOD_CONTROL;
    exp_grant  = '0;
    exp_sel    = NULL_ID;
    exp_pstart = 1'b0;
    exp_dc     = '0;
    exp_num    = '0;
  endtask

  task automatic model_step();
    logic [4:0] prev_grant;
    int lbl, cand, rr_n, pos;
    bit found;
    s_cx = int'(bus.cx);
    lbl  = (s_cx + 1) % H_TOTAL;
    if (!reset_n) begin
      model_reset();
    end else begin
      prev_grant = exp_grant;
      exp_grant  = '0;
      exp_pstart = 1'b0;
      if (!m_on) begin
        if (s_cx == ISLAND_START - 1) begin
          m_n     = ($countones(bus.req) < FIT) ? $countones(bus.req) : FIT;
          exp_num = 5'(m_n);
          m_on    = (m_n > 0);
          m_off   = 0;
        end
      end else begin
        m_off++;
        if (m_off == 12 + 32*m_n) m_on = 1'b0;
      end

      exp_dc = '0;
      if (!m_on) begin
        exp_mode = PERIOD_CONTROL;
        exp_sel  = NULL_ID;
      end else if (m_off < 8) begin
        exp_mode = PERIOD_PREAMBLE;
        exp_sel  = NULL_ID;
      end else if (m_off < 10) begin
        exp_mode = PERIOD_GUARD;
        exp_sel  = NULL_ID;
      end else if (m_off < 10 + 32*m_n) begin
        exp_mode = PERIOD_DATA;
        pos      = (m_off - 10) % 32;
        exp_dc   = 5'(pos);
        if (pos == 0) begin
          exp_pstart = 1'b1;
          exp_sel    = NULL_ID;
          found      = 1'b0;
          rr_n       = NUM_SRC - RR_BASE;
          // Candidate order: fixed group by index, then RR group from pointer.
          for (int j = 0; j < NUM_SRC; j++) begin
            cand = (j < RR_BASE) ? j : RR_BASE + ((m_ptr - RR_BASE + (j - RR_BASE)) % rr_n);
            if (!found && bus.req[cand] && !prev_grant[cand]) begin
              found           = 1'b1;
              exp_sel         = 3'(cand);
              exp_grant[cand] = 1'b1;
              if (cand >= RR_BASE) m_ptr = (cand + 1 >= NUM_SRC) ? RR_BASE : cand + 1;
            end
          end
        end
      end else begin
        exp_mode = PERIOD_GUARD;
        exp_sel  = NULL_ID;
      end
    end
    mode_at[lbl]  = exp_mode;
    sel_at[lbl]   = exp_sel;
    grant_at[lbl] = exp_grant;
    if (exp_grant != 0) grant_total++;
  endtask

  task automatic compare_all();
    check("grant",        32'(bus.grant),        32'(exp_grant));
    check("mode",         32'(bus.mode),         32'(exp_mode));
    check("packet_sel",   32'(bus.packet_sel),   32'(exp_sel));
    check("packet_start", 32'(bus.packet_start), 32'(exp_pstart));
    check("data_counter", 32'(bus.data_counter), 32'(exp_dc));
    check("num_packets",  32'(bus.num_packets),  32'(exp_num));
  endtask

  task automatic cycle();
    @(posedge clk_pixel);
    model_step();
    @(negedge clk_pixel);
    compare_all();
  endtask

  task automatic run_line(input int tid);
    for (int c = 0; c < H_TOTAL; c++) begin
      bus.req = bus.req & ~bus.grant;   // sources release once granted
      bus.cx  = BIT_WIDTH'(c);
      if (tid == 10 && c >= 660 && c < 670) bus.cx = BIT_WIDTH'(c - 660);
      case (tid)
        1, 7, 8: if (c == 0) bus.req = 5'b00001;
        2:       if (c == 0) bus.req = 5'b11111;
        4: begin
          if (c == 0)   bus.req    = 5'b00011;
          if (c == 660) bus.req[1] = 1'b0;
        end
        5:       if (c == ISLAND_START) bus.req[2] = 1'b1;
        9: begin
          for (int s = 0; s < NUM_SRC; s++) begin
            if (!bus.req[s] && $urandom_range(0, 399) == 0) bus.req[s] = 1'b1;
            else if (bus.req[s] && $urandom_range(0, 2999) == 0) bus.req[s] = 1'b0;
          end
        end
        10:      if (c == 0) bus.req = bus.req | 5'b00011;
        default: ;
      endcase
      if (tid == 7 && c == 670) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("arst_mode",  32'(bus.mode),         32'(PERIOD_CONTROL));
        check("arst_dc",    32'(bus.data_counter), 32'd0);
        check("arst_grant", 32'(bus.grant),        32'd0);
      end
      if (tid == 7 && c == 673) reset_n = 1'b1;
      cycle();
    end
  endtask

  initial begin
    bus.cx  = '0;
    bus.req = '0;
    s_cx    = 0;
    grant_total = 0;
    model_reset();
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("reset_mode",   32'(bus.mode),         32'(PERIOD_CONTROL));
    check("reset_grant",  32'(bus.grant),        32'd0);
    check("reset_sel",    32'(bus.packet_sel),   32'd7);
    check("reset_pstart", 32'(bus.packet_start), 32'd0);
    check("reset_dc",     32'(bus.data_counter), 32'd0);
    check("reset_num",    32'(bus.num_packets),  32'd0);
    reset_n = 1'b1;

    // No requests for three lines.
    for (int l = 0; l < 3; l++) run_line(0);
    check("idle_grants", 32'(grant_total), 32'd0);
    check("idle_num",    32'(exp_num),     32'd0);

    // Single packet from src0.
    run_line(1);
    check("one_num",    32'(exp_num),     32'd1);
    check("one_m643",   32'(mode_at[643]), 32'(PERIOD_CONTROL));
    check("one_m644",   32'(mode_at[644]), 32'(PERIOD_PREAMBLE));
    check("one_m651",   32'(mode_at[651]), 32'(PERIOD_PREAMBLE));
    check("one_m652",   32'(mode_at[652]), 32'(PERIOD_GUARD));
    check("one_m653",   32'(mode_at[653]), 32'(PERIOD_GUARD));
    check("one_m654",   32'(mode_at[654]), 32'(PERIOD_DATA));
    check("one_m685",   32'(mode_at[685]), 32'(PERIOD_DATA));
    check("one_m686",   32'(mode_at[686]), 32'(PERIOD_GUARD));
    check("one_m687",   32'(mode_at[687]), 32'(PERIOD_GUARD));
    check("one_m688",   32'(mode_at[688]), 32'(PERIOD_CONTROL));
    check("one_g654",   32'(grant_at[654]), 32'd1);
    check("one_sel655", 32'(sel_at[655]),   32'd0);

    // All five requesting: clamp to 4, then src4 on the next line.
    run_line(2);
    check("all_num",  32'(exp_num),       32'd4);
    check("all_g654", 32'(grant_at[654]), 32'd1);
    check("all_g686", 32'(grant_at[686]), 32'd2);
    check("all_g718", 32'(grant_at[718]), 32'd4);
    check("all_g750", 32'(grant_at[750]), 32'd8);
    check("all_m784", 32'(mode_at[784]),  32'(PERIOD_CONTROL));
    run_line(3);
    check("rr_g654",  32'(grant_at[654]), 32'd16);
    check("rr_num",   32'(exp_num),       32'd1);

    // src1 drops before its slot: slot 1 is NULL, island length unchanged.
    run_line(4);
    check("drop_num",    32'(exp_num),       32'd2);
    check("drop_g654",   32'(grant_at[654]), 32'd1);
    check("drop_g686",   32'(grant_at[686]), 32'd0);
    check("drop_sel686", 32'(sel_at[686]),   32'd7);
    check("drop_m700",   32'(mode_at[700]),  32'(PERIOD_DATA));

    // Request arriving after decide waits a line.
    run_line(5);
    check("late_num",  32'(exp_num),      32'd0);
    check("late_m650", 32'(mode_at[650]), 32'(PERIOD_CONTROL));
    run_line(6);
    check("late_g654", 32'(grant_at[654]), 32'd4);
    check("late_num2", 32'(exp_num),       32'd1);

    // Asynchronous reset in the middle of DATA.
    run_line(7);
    check("arst_m668", 32'(mode_at[668]), 32'(PERIOD_DATA));
    check("arst_m700", 32'(mode_at[700]), 32'(PERIOD_CONTROL));
    check("arst_num",  32'(exp_num),      32'd0);
    run_line(8);
    check("post_g654", 32'(grant_at[654]), 32'd1);
    check("post_m688", 32'(mode_at[688]),  32'(PERIOD_CONTROL));

    // Random request traffic, then a line with cx jumping mid-island.
    for (int l = 0; l < 10; l++) run_line(9);
    run_line(10);
    run_line(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
